// File: rtl/rand_src_arbiter_if.sv
// Source-lane bundle and output stream of the random-source arbiter.
// The master modport drives the lanes and downstream ready.
interface rand_src_arbiter_if #(
    parameter int NUM_CH = 5,
    parameter int DATA_W = 7,
    parameter int CH_W   = $clog2(NUM_CH)
);
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH-1:0]        in_pop;
    logic [NUM_CH-1:0]        ch_mask;
    logic [1:0]               mode;
    logic [CH_W-1:0]          fixed_sel;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_valid;
    logic                     out_ready;

    modport master (
        output in_data, in_valid, ch_mask, mode, fixed_sel, out_ready,
        input  in_pop, out_data, out_ch, out_valid
    );

    modport slave (
        input  in_data, in_valid, ch_mask, mode, fixed_sel, out_ready,
        output in_pop, out_data, out_ch, out_valid
    );
endinterface

// File: rtl/rand_src_arbiter.sv
// Merges NUM_CH random-source lanes into one registered ready/valid stream
// using round-robin, fixed or LFSR-seeded cyclic lane selection.
module rand_src_arbiter #(
    parameter int          NUM_CH    = 5,
    parameter int          DATA_W    = 7,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input logic               clk,
    input logic               rst,
    rand_src_arbiter_if.slave bus
);
    localparam int CH_W    = $clog2(NUM_CH);
    localparam int NUM_P2  = 1 << CH_W;
    localparam bit IS_POW2 = (NUM_P2 == NUM_CH);

    logic [CH_W-1:0]   ptr;
    logic [CH_W-1:0]   rr_start;
    logic [CH_W-1:0]   rand_start;
    logic [CH_W-1:0]   start;
    logic [CH_W-1:0]   gnt_idx;
    logic [15:0]       lfsr;
    logic [15:0]       lfsr_nxt;
    logic [15:0]       lfsr_rem;
    logic [NUM_CH-1:0] elig;
    logic [NUM_P2-1:0] elig_ext;
    logic [DATA_W-1:0] gnt_data;
    logic [DATA_W-1:0] out_data_q;
    logic [CH_W-1:0]   out_ch_q;
    logic              out_valid_q;
    logic              any_grant;
    logic              load;

    assign elig     = bus.in_valid & bus.ch_mask;
    assign elig_ext = NUM_P2'(elig);
    assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

    always_comb begin
        lfsr_rem = lfsr % 16'(NUM_CH);
        if (IS_POW2)
            lfsr_rem = 16'(lfsr[CH_W-1:0]);
    end

    assign rand_start = lfsr_rem[CH_W-1:0];
    assign rr_start   = (ptr == CH_W'(NUM_CH - 1)) ? '0 : ptr + 1'b1;
    assign start      = (bus.mode == 2'b10) ? rand_start : rr_start;

    // Cyclic first-set scan; mode 11 falls into the round-robin path.
    always_comb begin
        int j;
        j         = 0;
        any_grant = 1'b0;
        gnt_idx   = '0;
        unique case (1'b1)
            (bus.mode == 2'b01): begin
                if (32'(bus.fixed_sel) < NUM_CH && elig_ext[bus.fixed_sel]) begin
                    any_grant = 1'b1;
                    gnt_idx   = bus.fixed_sel;
                end
            end
            default: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    j = int'(start) + i;
                    if (j >= NUM_CH)
                        j = j - NUM_CH;
                    if (!any_grant && elig[j]) begin
                        any_grant = 1'b1;
                        gnt_idx   = CH_W'(j);
                    end
                end
            end
        endcase
    end

    always_comb begin
        gnt_data = '0;
        for (int k = 0; k < NUM_CH; k++)
            if (CH_W'(k) == gnt_idx)
                gnt_data = bus.in_data[k*DATA_W +: DATA_W];
    end

    // Gated by rst so no lane is popped while the output is being cleared.
    assign load       = any_grant && (!out_valid_q || bus.out_ready) && !rst;
    assign bus.in_pop = load ? (NUM_CH'(1) << gnt_idx) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= CH_W'(NUM_CH - 1);
            lfsr        <= LFSR_SEED;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            lfsr <= lfsr_nxt;
            if (load) begin
                out_data_q  <= gnt_data;
                out_ch_q    <= gnt_idx;
                out_valid_q <= 1'b1;
                ptr         <= gnt_idx;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rand_src_arbiter.sv
// Directed checks of the random-source arbiter: round-robin, masking,
// backpressure, fixed and LFSR modes, and asynchronous reset.
module tb_rand_src_arbiter;
    localparam int NUM_CH = 5;
    localparam int DATA_W = 7;

    logic clk;
    logic rst;
    int   checks;
    int   fails;
    int   exp_ch;
    int   hits [NUM_CH];
    logic [15:0] m_lfsr;

    rand_src_arbiter_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus_if ();

    rand_src_arbiter #(
        .NUM_CH   (NUM_CH),
        .DATA_W   (DATA_W),
        .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, Galois, right shift.
    always @(posedge clk or posedge rst) begin
        if (rst)
            m_lfsr <= 16'hACE1;
        else
            m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int ch, input logic v);
        chk({tag, "_valid"}, 32'(bus_if.out_valid), 32'(v));
        chk({tag, "_ch"}, 32'(bus_if.out_ch), 32'(ch));
        chk({tag, "_data"}, 32'(bus_if.out_data), 32'(8'h10 + ch));
    endtask

    initial begin
        int seq [6];
        checks = 0;
        fails  = 0;
        foreach (hits[i]) hits[i] = 0;
        seq = '{2, 4, 0, 2, 4, 0};

        rst               = 1'b1;
        bus_if.in_data    = {7'h14, 7'h13, 7'h12, 7'h11, 7'h10};
        bus_if.in_valid   = 5'b11111;
        bus_if.ch_mask    = 5'b11111;
        bus_if.mode       = 2'b00;
        bus_if.fixed_sel  = 3'd0;
        bus_if.out_ready  = 1'b1;
        tick();
        tick();
        chk("rst_valid", 32'(bus_if.out_valid), 0);
        chk("rst_data", 32'(bus_if.out_data), 0);
        chk("rst_ch", 32'(bus_if.out_ch), 0);
        chk("rst_pop", 32'(bus_if.in_pop), 0);

        rst = 1'b0;
        #1;
        exp_ch = 0;
        for (int i = 0; i < 7; i++) begin
            chk("rr_pop", 32'(bus_if.in_pop), 32'(1) << exp_ch);
            tick();
            chk_out("rr", exp_ch, 1'b1);
            exp_ch = (exp_ch + 1) % NUM_CH;
        end

        // Last grant was lane 1, so the scan resumes at lane 2.
        bus_if.ch_mask = 5'b10101;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("mask_pop", 32'(bus_if.in_pop), 32'(1) << seq[i]);
            chk("mask_skip", 32'(bus_if.in_pop & 5'b01010), 0);
            tick();
            chk_out("mask", seq[i], 1'b1);
        end

        bus_if.ch_mask = 5'b00000;
        #1;
        chk("nomask_pop", 32'(bus_if.in_pop), 0);
        tick();
        chk_out("nomask", 0, 1'b0);

        bus_if.ch_mask = 5'b00100;
        #1;
        chk("bp_load_pop", 32'(bus_if.in_pop), 32'b00100);
        tick();
        chk_out("bp_load", 2, 1'b1);
        bus_if.out_ready = 1'b0;
        bus_if.ch_mask   = 5'b11111;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("bp_pop", 32'(bus_if.in_pop), 0);
            tick();
            chk_out("bp_hold", 2, 1'b1);
        end
        bus_if.out_ready = 1'b1;
        #1;
        chk("bp_rel_pop", 32'(bus_if.in_pop), 32'b01000);
        tick();
        chk_out("bp_rel", 3, 1'b1);

        bus_if.mode      = 2'b01;
        bus_if.fixed_sel = 3'd3;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("fix_pop", 32'(bus_if.in_pop), 32'b01000);
            tick();
            chk_out("fix", 3, 1'b1);
        end
        bus_if.fixed_sel = 3'd6;
        #1;
        chk("fix_oor_pop", 32'(bus_if.in_pop), 0);
        tick();
        chk_out("fix_oor", 3, 1'b0);
        bus_if.fixed_sel = 3'd3;
        bus_if.in_valid  = 5'b10111;
        #1;
        chk("fix_inv_pop", 32'(bus_if.in_pop), 0);
        tick();
        chk_out("fix_inv", 3, 1'b0);
        bus_if.in_valid = 5'b11111;

        bus_if.mode = 2'b11;
        #1;
        chk("m11_pop", 32'(bus_if.in_pop), 32'b10000);
        tick();
        chk_out("m11", 4, 1'b1);

        bus_if.mode = 2'b10;
        #1;
        for (int i = 0; i < 1000; i++) begin
            exp_ch = int'(m_lfsr % 16'd5);
            hits[exp_ch]++;
            chk("rnd_pop", 32'(bus_if.in_pop), 32'(1) << exp_ch);
            tick();
            chk("rnd_ch", 32'(bus_if.out_ch), 32'(exp_ch));
        end
        for (int k = 0; k < NUM_CH; k++) begin
            checks++;
            assert (hits[k] >= 150) else begin
                fails++;
                $error("FAIL rnd_hits lane %0d: got %0d want >=150", k, hits[k]);
            end
        end

        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 32'(bus_if.out_valid), 0);
        chk("arst_data", 32'(bus_if.out_data), 0);
        chk("arst_ch", 32'(bus_if.out_ch), 0);
        chk("arst_pop", 32'(bus_if.in_pop), 0);
        bus_if.mode = 2'b00;
        tick();
        rst = 1'b0;
        #1;
        chk("arst_rel_pop", 32'(bus_if.in_pop), 32'b00001);
        tick();
        chk_out("arst_rel", 0, 1'b1);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
